truth_table_sequencer: RTL
==========================

// Module: truth_table_sequencer
// PURPOSE
//  Sequences a 4-input combinational function block f(a,b,c,d). After start it sweeps
//  all 16 input codes in ascending order (a = MSB, d = LSB) and waits a settle period
//  per code. It samples f, builds the observed truth table and compares it bit-for-bit
//  against an expected 16-bit mask. It is the on-chip self-check front end for the
//  lab's 4-variable logic functions.
// PARAMETERS
//  SETTLE_CYCLES  2  clocks held per code before f is sampled; legal range 1..15
// PORTS
//  clk         in   1   system clock, rising-edge
//  rst         in   1   synchronous, active-high reset
//  start       in   1   begin a sweep; sampled only in IDLE or DONE
//  expected    in   16  expected table; bit i = f for code i; latched at start
//  f_in        in   1   output of the function block under control
//  a,b,c,d     out  1   function inputs; {a,b,c,d} = current code
//  busy        out  1   high from the cycle after start until the sweep ends
//  done        out  1   high in DONE; held until the next start or rst
//  pass        out  1   valid when done=1; 1 iff err_count == 0
//  table_out   out  16  observed table; bit i is written when code i is sampled
//  err_count   out  5   number of mismatching codes, 0..16
//  first_fail  out  4   lowest mismatching code; meaningful only if err_count != 0
// BEHAVIOUR
//  - Clock and reset: one clock; reset is synchronous and active-high.
//  - Reset value of every output: 0. On rst, state = IDLE and idx = 0.
//  - rst during a sweep aborts it immediately. No partial results are kept.
//  - FSM states: IDLE, DRIVE, WAIT, SAMPLE, DONE.
//  - IDLE/DONE + start: latch expected, set idx = 0, clear table_out, err_count,
//    first_fail, done and pass, then go to DRIVE.
//  - DRIVE: {a,b,c,d} <= idx. Go to WAIT and load settle counter = SETTLE_CYCLES-1.
//  - WAIT: decrement the counter each clock. When it reaches 0, go to SAMPLE.
//    Inputs are therefore stable for exactly SETTLE_CYCLES clocks before sampling.
//  - SAMPLE: table_out[idx] <= f_in.
//    - If f_in != exp_q[idx]: err_count += 1. If this is the first mismatch, first_fail <= idx.
//    - If idx == 15: go to DONE. Otherwise idx += 1 and go to DRIVE.
//  - DONE: busy = 0, done = 1, pass = (err_count == 0).
//    {a,b,c,d} keep holding code 15 until the next start.
//  - busy = 1 in DRIVE, WAIT and SAMPLE.
//  - Timing: cycles per code = SETTLE_CYCLES + 2.
//    done rises 16*(SETTLE_CYCLES+2)+1 clocks after the start edge; that is 65 at the default.
//  - start while busy is ignored. The expected input is not re-latched mid-sweep.
//  - start held high in DONE restarts on the next edge, with a full clear.
//  - idx is 4 bits. The sweep terminates on idx==15 and never wraps to 0 mid-sweep.
//  - err_count saturates naturally at 16 because there are only 16 codes.
//    It is 5 bits wide so that 16 is representable.
//  - f_in is treated as a combinational function of {a,b,c,d}; no synchroniser is applied.
// TESTING
//  1. Apply rst for 2 clocks with start=0.
//     -> All outputs are 0 and remain 0 for 10 further idle clocks.
//  2. Model f=a&b&c&d, expected=16'h8000, pulse start.
//     -> busy=1 for 64 clocks, then done=1 at +65.
//     -> pass=1, table_out=16'h8000, err_count=0.
//  3. Model f=a^b^c^d (true table 16'h6996), expected=16'h6D94 (bits 1 and 10 wrong).
//     -> table_out=16'h6996, err_count=2, first_fail=1, pass=0.
//  4. Model f=0, expected=16'hFFFF.
//     -> err_count=16, first_fail=0, pass=0, table_out=16'h0000.
//  5. Pulse start again at code 5 mid-sweep, then change expected.
//     -> Ignored: done still at +65 from the original start, and the compare uses the original mask.
//     -> With start held high in DONE, a new sweep begins and done drops the next clock.
//  6. Assert rst while {a,b,c,d}=4'd7.
//     -> Next clock all outputs are 0 and state is IDLE.
//     -> A following start performs a complete 16-code sweep with correct results.

Source files
------------

// File: rtl/truth_table_sequencer.sv
// Sweeps all 16 input codes of a 4-input function block, samples f after a settle
// period and compares the observed truth table against a latched expected mask.
module truth_table_sequencer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] expected,
    input  logic        f_in,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] table_out,
    output logic [4:0]  err_count,
    output logic [3:0]  first_fail
);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WAIT,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  idx;
    logic [3:0]  cnt;
    logic [15:0] exp_q;
    logic        go;
    logic        mismatch;

    assign go       = start && (state == IDLE || state == DONE);
    assign mismatch = (f_in != exp_q[idx]);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: if (start) state_nxt = DRIVE;
            DRIVE:      state_nxt = WAIT;
            WAIT:       if (cnt == 4'd0) state_nxt = SAMPLE;
            SAMPLE:     state_nxt = (idx == 4'd15) ? DONE : DRIVE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Status flags are registered from the state, so they trail it by one clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            {a, b, c, d} <= 4'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            table_out    <= 16'd0;
            err_count    <= 5'd0;
            first_fail   <= 4'd0;
            idx          <= 4'd0;
            cnt          <= 4'd0;
            exp_q        <= 16'd0;
        end else begin
            busy <= (state == DRIVE) || (state == WAIT) || (state == SAMPLE);
            done <= (state == DONE);
            pass <= (state == DONE) && (err_count == 5'd0);
            case (state)
                DRIVE: begin
                    {a, b, c, d} <= idx;
                    cnt          <= SETTLE_LOAD;
                end
                WAIT: begin
                    if (cnt != 4'd0) cnt <= cnt - 4'd1;
                end
                SAMPLE: begin
                    table_out[idx] <= f_in;
                    if (mismatch) begin
                        err_count <= err_count + 5'd1;
                        if (err_count == 5'd0) first_fail <= idx;
                    end
                    if (idx != 4'd15) idx <= idx + 4'd1;
                end
                default: ;
            endcase
            if (go) begin
                exp_q      <= expected;
                idx        <= 4'd0;
                table_out  <= 16'd0;
                err_count  <= 5'd0;
                first_fail <= 4'd0;
                done       <= 1'b0;
                pass       <= 1'b0;
            end
        end
    end

endmodule
